// File: rtl/pair_align.sv
// pair_align: buffers two sample streams and presents their FIFO heads as beat-locked pairs,
// truncating and resynchronising on packet-length mismatch. Optional: PAIR_ALIGN_DROP_COUNT_EN.
module pair_align #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic [2*WIDTH-1:0]   i0_tdata,
   input  logic                 i0_tlast,
   input  logic                 i0_tvalid,
   output logic                 i0_tready,
   input  logic [2*WIDTH-1:0]   i1_tdata,
   input  logic                 i1_tlast,
   input  logic                 i1_tvalid,
   output logic                 i1_tready,
   output logic [2*WIDTH-1:0]   o0_tdata,
   output logic                 o0_tlast,
   output logic                 o0_tvalid,
   input  logic                 o0_tready,
   output logic [2*WIDTH-1:0]   o1_tdata,
   output logic                 o1_tlast,
   output logic                 o1_tvalid,
   input  logic                 o1_tready,
   output logic                 err_pulse,
   output logic [15:0]          err_count,
   output logic [15:0]          drop_count
);

   localparam int DW    = 2 * WIDTH;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   typedef enum logic [1:0] {ALIGN, DRAIN0, DRAIN1} state_t;

   state_t              state_q, state_d;
   logic [DEPTH_LOG2:0] wr0_q, wr0_d, rd0_q, rd0_d;
   logic [DEPTH_LOG2:0] wr1_q, wr1_d, rd1_q, rd1_d;
   logic [DW:0]         mem0_q [DEPTH];
   logic [DW:0]         mem1_q [DEPTH];
   logic [DW:0]         head0, head1;
   logic                empty0, full0, empty1, full1;
   logic                push0, push1, pop0, pop1;
   logic                pair_valid, err_d, err_pulse_q;
   logic [15:0]         err_count_q, err_count_d;

   always_comb begin
      empty0 = (wr0_q == rd0_q);
      empty1 = (wr1_q == rd1_q);
      // Extra pointer MSB distinguishes full from empty when the index bits match.
      full0  = (wr0_q[DEPTH_LOG2] != rd0_q[DEPTH_LOG2]) &&
               (wr0_q[DEPTH_LOG2-1:0] == rd0_q[DEPTH_LOG2-1:0]);
      full1  = (wr1_q[DEPTH_LOG2] != rd1_q[DEPTH_LOG2]) &&
               (wr1_q[DEPTH_LOG2-1:0] == rd1_q[DEPTH_LOG2-1:0]);
      head0  = mem0_q[rd0_q[DEPTH_LOG2-1:0]];
      head1  = mem1_q[rd1_q[DEPTH_LOG2-1:0]];
      push0  = i0_tvalid && !full0 && !clear;
      push1  = i1_tvalid && !full1 && !clear;

      state_d    = state_q;
      pop0       = 1'b0;
      pop1       = 1'b0;
      pair_valid = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         ALIGN: begin
            pair_valid = !empty0 && !empty1 && !clear;
            if (pair_valid && o0_tready && o1_tready) begin
               pop0 = 1'b1;
               pop1 = 1'b1;
               if (head0[DW] && !head1[DW]) begin
                  err_d   = 1'b1;
                  state_d = DRAIN1;
               end else if (!head0[DW] && head1[DW]) begin
                  err_d   = 1'b1;
                  state_d = DRAIN0;
               end
            end
         end
         DRAIN0: begin
            if (!empty0 && !clear) begin
               pop0 = 1'b1;
               if (head0[DW]) state_d = ALIGN;
            end
         end
         DRAIN1: begin
            if (!empty1 && !clear) begin
               pop1 = 1'b1;
               if (head1[DW]) state_d = ALIGN;
            end
         end
         default: state_d = ALIGN;
      endcase

      if (clear) begin
         state_d = ALIGN;
         wr0_d   = '0;
         rd0_d   = '0;
         wr1_d   = '0;
         rd1_d   = '0;
      end else begin
         wr0_d = push0 ? wr0_q + PTR_ONE : wr0_q;
         rd0_d = pop0  ? rd0_q + PTR_ONE : rd0_q;
         wr1_d = push1 ? wr1_q + PTR_ONE : wr1_q;
         rd1_d = pop1  ? rd1_q + PTR_ONE : rd1_q;
      end

      err_count_d = (err_d && (err_count_q != '1)) ? err_count_q + 16'd1 : err_count_q;
   end

   always_ff @(posedge clk) begin
      if (push0) mem0_q[wr0_q[DEPTH_LOG2-1:0]] <= {i0_tlast, i0_tdata};
      if (push1) mem1_q[wr1_q[DEPTH_LOG2-1:0]] <= {i1_tlast, i1_tdata};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ALIGN;
         wr0_q       <= '0;
         rd0_q       <= '0;
         wr1_q       <= '0;
         rd1_q       <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         wr0_q       <= wr0_d;
         rd0_q       <= rd0_d;
         wr1_q       <= wr1_d;
         rd1_q       <= rd1_d;
         err_pulse_q <= err_d;
         err_count_q <= err_count_d;
      end
   end

`ifdef PAIR_ALIGN_DROP_COUNT_EN
   logic        drop_beat;
   logic [15:0] drop_count_q, drop_count_d;

   always_comb begin
      drop_beat    = ((state_q == DRAIN0) && pop0) || ((state_q == DRAIN1) && pop1);
      drop_count_d = (drop_beat && (drop_count_q != '1)) ? drop_count_q + 16'd1 : drop_count_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) drop_count_q <= '0;
      else          drop_count_q <= drop_count_d;
   end

   assign drop_count = drop_count_q;
`else
   assign drop_count = '0;
`endif

   // A mismatched pair is truncated: either head carrying tlast ends the output packet.
   assign o0_tvalid = pair_valid;
   assign o1_tvalid = pair_valid;
   assign o0_tlast  = pair_valid && (head0[DW] || head1[DW]);
   assign o1_tlast  = o0_tlast;
   assign o0_tdata  = pair_valid ? head0[DW-1:0] : '0;
   assign o1_tdata  = pair_valid ? head1[DW-1:0] : '0;
   assign i0_tready = !full0;
   assign i1_tready = !full1;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule
